// File: rtl/pwr_arb_pkg.sv
// Shared types and defaults for the round-robin multiplier arbiter.
package pwr_arb_pkg;

  localparam int unsigned N_DEF   = 4;
  localparam int unsigned W_DEF   = 8;
  localparam int unsigned LAT_DEF = 2;

  function automatic int unsigned id_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned ID_W_DEF = id_width(N_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mul_pipe.sv
// Registered unsigned W x W multiplier, LAT register stages, async active-low clear.
module mul_pipe #(
  parameter int unsigned W   = 8,
  parameter int unsigned LAT = 2
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           ld_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] p_o
);

  logic [W-1:0]   a_q, b_q;
  logic [2*W-1:0] prod;

  // The operand register is the first of the LAT stages and holds until the next load.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q <= '0;
      b_q <= '0;
    end else if (ld_i) begin
      a_q <= a_i;
      b_q <= b_i;
    end
  end

  assign prod = (2*W)'(a_q) * (2*W)'(b_q);

  generate
    if (LAT == 1) begin : g_comb
      assign p_o = prod;
    end else begin : g_pipe
      logic [2*W-1:0] stage_q [LAT-1];

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int unsigned i = 0; i < LAT - 1; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= prod;
          for (int unsigned i = 1; i < LAT - 1; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign p_o = stage_q[LAT-2];
    end
  endgenerate

endmodule

// File: rtl/pwr_arbiter.sv
// Round-robin arbiter sharing one registered multiplier among N requesters.
module pwr_arbiter
  import pwr_arb_pkg::*;
#(
  parameter int unsigned N   = N_DEF,
  parameter int unsigned W   = W_DEF,
  parameter int unsigned LAT = LAT_DEF
) (
  input  logic                   CLK,
  input  logic                   aRSTin,
  input  logic [N-1:0]           req,
  input  logic [N*W-1:0]         opa,
  input  logic [N*W-1:0]         opb,
  output logic [N-1:0]           ack,
  output logic                   vld,
  output logic [id_width(N)-1:0] rid,
  output logic [2*W-1:0]         result,
  output logic                   busy
);

  localparam int unsigned IDW = id_width(N);
  localparam int unsigned CW  = $clog2(LAT + 1);

  logic [1:0]     sync_q;
  logic           rst_n;
  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IDW-1:0] id_q, id_d, ptr_q, ptr_d, rid_q, rid_d, gnt;
  logic [N-1:0]   ack_q, ack_d;
  logic           vld_q, vld_d;
  logic [2*W-1:0] result_q, result_d, mul_p;
  logic [W-1:0]   sel_a, sel_b;
  logic           hit, ld;
  int unsigned    idx;

  // Assert asynchronously, release two edges after aRSTin rises.
  always_ff @(posedge CLK or negedge aRSTin) begin
    if (!aRSTin) sync_q <= '0;
    else         sync_q <= {sync_q[0], 1'b1};
  end

  assign rst_n = sync_q[1];

  always_comb begin
    hit   = 1'b0;
    gnt   = '0;
    idx   = 0;
    sel_a = '0;
    sel_b = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!hit && req[IDW'(idx)]) begin
        hit = 1'b1;
        gnt = IDW'(idx);
      end
    end
    for (int unsigned j = 0; j < N; j++) begin
      if (gnt == IDW'(j)) begin
        sel_a = opa[j*W +: W];
        sel_b = opb[j*W +: W];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    id_d     = id_q;
    ptr_d    = ptr_q;
    rid_d    = rid_q;
    result_d = result_q;
    ack_d    = '0;
    vld_d    = 1'b0;
    ld       = 1'b0;
    case (state_q)
      IDLE: begin
        if (hit) begin
          state_d    = MUL;
          cnt_d      = CW'(LAT);
          id_d       = gnt;
          ack_d[gnt] = 1'b1;
          ld         = 1'b1;
        end
      end
      MUL: begin
        if (cnt_q == CW'(1)) begin
          state_d  = DONE;
          vld_d    = 1'b1;
          rid_d    = id_q;
          result_d = mul_p;
          ptr_d    = (id_q == IDW'(N - 1)) ? '0 : id_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      id_q     <= '0;
      ptr_q    <= '0;
      rid_q    <= '0;
      ack_q    <= '0;
      vld_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      id_q     <= id_d;
      ptr_q    <= ptr_d;
      rid_q    <= rid_d;
      ack_q    <= ack_d;
      vld_q    <= vld_d;
      result_q <= result_d;
    end
  end

  mul_pipe #(
    .W   (W),
    .LAT (LAT)
  ) u_mul (
    .clk_i  (CLK),
    .rst_ni (rst_n),
    .ld_i   (ld),
    .a_i    (sel_a),
    .b_i    (sel_b),
    .p_o    (mul_p)
  );

  assign ack    = ack_q;
  assign vld    = vld_q;
  assign rid    = rid_q;
  assign result = result_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: doc/pwr_arbiter.md
# pwr_arbiter

Shares one registered W×W unsigned multiplier between N requesters. Each requester posts an operand pair with a level request. The block grants requests round-robin, drives the shared multiplier, and returns the product tagged with the requester index. It sits between the counter/squarer datapath clients and the single multiplier instance, and replaces per-client multipliers.

## Interface
- N, 4: number of requesters (≥2)
- W, 8: operand width; product width is 2W
- LAT, 2: multiplier register stages (≥1)

- CLK  in  1  rising-edge clock
- aRSTin  in  1  asynchronous reset, active-low
- req  in  N  per-requester level request; hold until own ack
- opa  in  N*W  operand A, requester i at [i*W +: W]
- opb  in  N*W  operand B, same packing
- ack  out  N  one-hot, one-cycle pulse: operands of requester i captured
- vld  out  1  one-cycle pulse: result/rid valid
- rid  out  $clog2(N)  index of requester owning result
- result  out  2W  opa*opb, unsigned, exact
- busy  out  1  high when state ≠ IDLE

## Operation
- Reset synchronizer: two flops, asserted asynchronously by aRSTin low, deasserted after 2 CLK edges following aRSTin high. The internal reset clears all state. Requests are ignored while it is asserted.
- FSM states and transitions:
  - IDLE → MUL when any req is high.
  - MUL → DONE after LAT cycles.
  - DONE → IDLE.
- IDLE grant rule: search for a high req starting at index ptr, ascending, wrapping modulo N. The first hit g is granted.
- At the IDLE→MUL edge:
  - latch opa[g], opb[g] into operand registers and feed them to the multiplier;
  - set ack[g] for one cycle;
  - latch g as the current id.
- MUL: a down-counter loaded with LAT decrements each cycle; exit on the count reaching 1.
- DONE entry edge:
  - register the multiplier output into result;
  - rid ← g;
  - vld high for one cycle;
  - ptr ← (g+1) mod N.
- result and rid hold their values until the next vld.
- A req dropped before its ack is simply not served; there is no error.
- A req held high after ack is re-requested and is served again only after the round-robin pointer passes it.
- Operands are sampled once, at grant. Later changes on opa/opb do not affect the product.
- Reset values: ack=0, vld=0, rid=0, result=0, busy=0, ptr=0, state=IDLE.
- Reset mid-operation: the in-flight op is discarded, no vld is issued, and all outputs return to reset values immediately (asynchronously).

## Timing
- req is sampled in IDLE during cycle c0.
- ack is high during c1.
- vld, result and rid are valid during c(LAT+1).
- The FSM is back in IDLE at c(LAT+2).
- Throughput: one op per LAT+2 cycles under continuous request.
- Simultaneous requests never produce more than one ack bit per cycle.
- The earliest a requester can drop req is c2. This is always before the next IDLE sample.
- ptr wraps from N-1 to 0.

## Structure
- Package pwr_arb_pkg holds:
  - the state enum typedef (IDLE, MUL, DONE);
  - default N, W and LAT localparams;
  - a clog2-based id-width constant.
- Sub-module mul_pipe (W, LAT): registered unsigned multiplier with LAT stages and asynchronous active-low clear.
- The reset synchronizer and round-robin picker are inline in pwr_arbiter.

## Test plan
- Reset:
  - Stimulus: aRSTin low for 3 cycles, req=4'hF held.
  - Response: all outputs 0 during reset and for 2 cycles after release; the first ack is ack[0].
- Single request:
  - Stimulus: N=4, W=8, LAT=2; req[2] with opa=8'hFF, opb=8'hFF.
  - Response: ack=4'b0100 in c1; vld in c3 with result=16'hFE01 and rid=2; busy low again in c4.
- All requesters, held high:
  - Stimulus: req=4'hF held; requester i drives opa=i+1, opb=3.
  - Response: results 3, 6, 9, 12 with rid 0, 1, 2, 3, then rid 0 again; vld every 4 cycles.
- Fairness:
  - Stimulus: after a grant to requester 1, present req[0] and req[1] together.
  - Response: grant 0 (search order 2, 3, 0), then grant 1.
- Reset mid-operation:
  - Stimulus: aRSTin low during MUL.
  - Response: no vld; result=0, busy=0; after release, a pending req[3] is granted first at ptr=0 (search 0, 1, 2, 3).
- Zero operand and operand change after grant:
  - Stimulus: opa=0, opb=8'hAB; change opb after ack.
  - Response: result=16'h0000.
